// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer and its helpers.
package alarm_pkg;

  localparam int CNT_W   = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_e;

  function automatic logic is_armed(input state_e s);
    return (s == ARMED) || (s == ENTRY_DELAY) || (s == ALARM);
  endfunction

endpackage

// File: rtl/alarm_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module alarm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Intruder-alarm FSM: exit delay, armed watch, entry delay and timed siren.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int EXIT_DELAY_CYC  = 16,
  parameter int ENTRY_DELAY_CYC = 8,
  parameter int SIREN_CYC       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               trigger,
  output logic               system_armed,
  output logic               siren,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (EXIT_DELAY_CYC  < 1 || EXIT_DELAY_CYC  > CNT_MAX ||
      ENTRY_DELAY_CYC < 1 || ENTRY_DELAY_CYC > CNT_MAX ||
      SIREN_CYC       < 1 || SIREN_CYC       > CNT_MAX) begin : g_bad_param
    $error("alarm_sequencer: delay parameters must lie in 1..65535");
  end

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYC - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             trigger_s;
  logic             expired;

  alarm_sync2 u_trigger_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trigger),
    .q     (trigger_s)
  );

  assign expired = (count == '0);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    count_next = count - 1'b1;
    case (state)
      DISARMED: begin
        count_next = '0;
        if (arm_req) begin
          state_next = EXIT_DELAY;
          count_next = EXIT_LOAD;
        end
      end
      EXIT_DELAY: begin
        if (expired) state_next = ARMED;
      end
      ARMED: begin
        count_next = '0;
        if (trigger_s) begin
          state_next = ENTRY_DELAY;
          count_next = ENTRY_LOAD;
        end
      end
      ENTRY_DELAY: begin
        if (expired) begin
          state_next = ALARM;
          count_next = SIREN_LOAD;
        end
      end
      ALARM: begin
        if (expired) state_next = ARMED;
      end
      default: begin
        state_next = DISARMED;
        count_next = '0;
      end
    endcase
    // Disarm wins over arm requests and over a same-cycle expiry.
    if (disarm_req) begin
      state_next = DISARMED;
      count_next = '0;
    end
  end

  // Outputs are registered from the next-state decode so they always match
  // the state register without any combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DISARMED;
      count        <= '0;
      system_armed <= 1'b0;
      siren        <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      system_armed <= is_armed(state_next);
      siren        <= (state_next == ALARM);
    end
  end

  assign state_o = state;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter EXIT_DELAY_CYC, default 16, clock cycles spent in EXIT_DELAY after an accepted arm request.
REQ-002 Parameter ENTRY_DELAY_CYC, default 8, clock cycles spent in ENTRY_DELAY before the siren sounds.
REQ-003 Parameter SIREN_CYC, default 32, clock cycles the siren stays on before the block re-arms automatically.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 arm_req  input  1  single-cycle pulse from the keypad requesting arm; synchronous to clk.
REQ-007 disarm_req  input  1  single-cycle pulse from the keypad (valid code already checked); synchronous to clk.
REQ-008 trigger  input  1  IR beam-break alarm indication from the IR sensor stage; asynchronous to clk.
REQ-009 system_armed  output  1  armed indication; also fed back to the IR sensor stage.
REQ-010 siren  output  1  siren drive.
REQ-011 state_o  output  3  current state encoding, for status LEDs and debug.

Function
REQ-012 The block SHALL implement states DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3 and ALARM=4; encodings 5-7 are illegal and SHALL return to DISARMED on the next cycle.
REQ-013 trigger SHALL pass through a 2-flop synchroniser, giving trigger_s; an assertion SHALL become visible to the FSM 2 cycles after the first sampling edge.
REQ-014 DISARMED + arm_req SHALL go to EXIT_DELAY; arm_req SHALL be ignored in every other state.
REQ-015 On entry to any timed state, the 16-bit down-counter SHALL load that state's parameter minus 1 and decrement each cycle; the state SHALL exit on the cycle the counter reads 0, so the FSM occupies the state exactly N cycles.
REQ-016 EXIT_DELAY SHALL ignore trigger_s and go to ARMED when its count expires.
REQ-017 ARMED + trigger_s=1 SHALL go to ENTRY_DELAY.
REQ-018 ENTRY_DELAY expiry SHALL go to ALARM; trigger_s deasserting during ENTRY_DELAY SHALL NOT cancel it.
REQ-019 ALARM expiry SHALL go to ARMED; if trigger_s is still high, REQ-017 then applies on the next cycle.
REQ-020 disarm_req in any state other than DISARMED SHALL go to DISARMED on the next edge, with the counter cleared.
REQ-021 disarm_req SHALL take priority over arm_req when both are asserted in the same cycle, and over a counter expiry in the same cycle.
REQ-022 system_armed SHALL be 1 exactly in ARMED, ENTRY_DELAY and ALARM.
REQ-023 siren SHALL be 1 exactly in ALARM.
REQ-024 All outputs SHALL be registered and decoded from the state register, with no combinational path from any input.
REQ-025 Parameter values of 0 or above 65535 SHALL be rejected at elaboration.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
  - state to DISARMED;
  - the counter and both synchroniser flops to 0;
  - system_armed=0, siren=0, state_o=0.
REQ-027 Reset asserted mid-ALARM SHALL drop siren immediately, without waiting for a clock edge.
REQ-028 Release of rst_n SHALL take effect synchronously; the first state change SHALL occur no earlier than the first clk edge after release.

Structure
REQ-029 Package alarm_pkg SHALL hold:
  - the state enum and its encodings;
  - the counter width constant (16);
  - the state_o width constant.
REQ-030 The synchroniser SHALL be a separate sub-module, alarm_sync2, so the IR sensor stage can reuse it.
REQ-031 The FSM and counter SHALL reside in alarm_sequencer.

Verification (defaults)
REQ-032 Exit delay: arm_req pulse at cycle 0 -> EXIT_DELAY cycles 1-16, ARMED at cycle 17, system_armed rises at 17.
REQ-033 Trigger during exit: trigger held high during EXIT_DELAY -> ARMED at 17, then ENTRY_DELAY at 18, siren=0 throughout.
REQ-034 Full alarm: trigger asserted in ARMED at T -> ENTRY_DELAY from T+2 for 8 cycles, ALARM at T+10, siren high for 32 cycles, then ARMED.
REQ-035 Disarm during entry: disarm_req at ENTRY_DELAY cycle 5 -> DISARMED next edge, siren never asserts, system_armed=0.
REQ-036 Simultaneous requests: arm_req and disarm_req in the same cycle while DISARMED -> stays DISARMED; disarm_req on the same cycle as ENTRY_DELAY expiry -> DISARMED, not ALARM.
REQ-037 Reset mid-alarm: rst_n low at ALARM cycle 10 -> siren=0 and state_o=0 before the next clk edge; after release, arm_req restarts the full 16-cycle exit delay.
